cla_addsub_pipe: RTL and testbench



---
 rtl/cla_addsub_pipe.sv | 202 ++++++++++++++++++++
 tb/tb_cla_addsub_pipe.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor: one SEG-bit CLA segment per stage, registered carry between segments.
// Optional signed saturation of the result when CLA_ADDSUB_SAT_EN is defined.
module cla_addsub_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf,
  output logic             zero
);

  localparam int SEG = WIDTH / STAGES;
  localparam int NG  = (SEG + 3) / 4;
  localparam int NR  = (STAGES > 1) ? STAGES - 1 : 1;

  // Returns {carry into segment MSB, carry out, SEG-bit sum}.
  function automatic logic [SEG+1:0] cla_seg(input logic [SEG-1:0] x,
                                             input logic [SEG-1:0] y,
                                             input logic           cin);
    logic [SEG-1:0] g, p, sm;
    logic [NG-1:0]  gg, pp;
    logic [NG:0]    gc;
    logic [SEG:0]   c;
    logic           term;
    int             base;
    g = x & y;
    p = x ^ y;
    for (int j = 0; j < NG; j++) begin
      gg[j] = 1'b0;
      pp[j] = 1'b1;
      for (int i = 4 * j; i < 4 * j + 4 && i < SEG; i++) begin
        term = g[i];
        for (int l = i + 1; l < 4 * j + 4 && l < SEG; l++) term = term & p[l];
        gg[j] = gg[j] | term;
        pp[j] = pp[j] & p[i];
      end
    end
    // Group carries as flat sum-of-products over group generate/propagate.
    for (int j = 0; j <= NG; j++) begin
      gc[j] = cin;
      for (int l = 0; l < j; l++) gc[j] = gc[j] & pp[l];
      for (int m = 0; m < j; m++) begin
        term = gg[m];
        for (int l = m + 1; l < j; l++) term = term & pp[l];
        gc[j] = gc[j] | term;
      end
    end
    for (int i = 0; i < SEG; i++) begin
      base = (i / 4) * 4;
      c[i] = gc[i / 4];
      for (int l = base; l < i; l++) c[i] = c[i] & p[l];
      for (int m = base; m < i; m++) begin
        term = g[m];
        for (int l = m + 1; l < i; l++) term = term & p[l];
        c[i] = c[i] | term;
      end
    end
    c[SEG] = gc[NG];
    sm = p ^ c[SEG-1:0];
    return {c[SEG-1], c[SEG], sm};
  endfunction

`ifdef CLA_ADDSUB_SAT_EN
  function automatic logic [WIDTH-1:0] sat_result(input logic [WIDTH-1:0] raw,
                                                  input logic             of,
                                                  input logic             a_msb);
    logic [WIDTH-1:0] r;
    r = raw;
    if (of) r = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    return r;
  endfunction
`endif

  logic [WIDTH-1:0] a_d   [NR];
  logic [WIDTH-1:0] b_d   [NR];
  logic [WIDTH-1:0] sum_d [NR];
  logic             c_d   [NR];
  logic [WIDTH-1:0] a_q   [NR];
  logic [WIDTH-1:0] b_q   [NR];
  logic [WIDTH-1:0] sum_q [NR];
  logic             c_q   [NR];
  logic [NR-1:0]    vld_q;
  logic             last_vld;

  logic [WIDTH-1:0] s_d, s_q;
  logic             co_d, ovf_d, zero_d;
  logic             co_q, ovf_q, zero_q, out_valid_q;
  logic             advance;

  assign advance  = out_ready | ~out_valid_q;
  assign in_ready = advance;

  always_comb begin : stage_comb
    logic [WIDTH-1:0] xa, xb, xs;
    logic             xc;
    logic [SEG+1:0]   r;
    for (int k = 0; k < NR; k++) begin
      a_d[k]   = '0;
      b_d[k]   = '0;
      sum_d[k] = '0;
      c_d[k]   = 1'b0;
    end
    xa = a;
    xb = b ^ {WIDTH{sub}};
    xc = sub | ci;
    xs = '0;
    r  = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (k > 0) begin
        xa = a_q[(k > 0) ? k - 1 : 0];
        xb = b_q[(k > 0) ? k - 1 : 0];
        xc = c_q[(k > 0) ? k - 1 : 0];
        xs = sum_q[(k > 0) ? k - 1 : 0];
      end
      r = cla_seg(xa[k*SEG +: SEG], xb[k*SEG +: SEG], xc);
      xs[k*SEG +: SEG] = r[SEG-1:0];
      if (k < STAGES - 1) begin
        a_d[(k < NR) ? k : NR-1]   = xa;
        b_d[(k < NR) ? k : NR-1]   = xb;
        c_d[(k < NR) ? k : NR-1]   = r[SEG];
        sum_d[(k < NR) ? k : NR-1] = xs;
      end
    end
    co_d  = r[SEG];
    ovf_d = r[SEG+1] ^ r[SEG];
`ifdef CLA_ADDSUB_SAT_EN
    s_d = sat_result(xs, ovf_d, xa[WIDTH-1]);
`else
    s_d = xs;
`endif
    zero_d = ~|s_d;
  end

  generate
    if (STAGES > 1) begin : g_pipe
      // ---- inter-segment pipeline registers ----
      always_ff @(posedge clk) begin
        if (advance) begin
          for (int k = 0; k < NR; k++) begin
            a_q[k]   <= a_d[k];
            b_q[k]   <= b_d[k];
            c_q[k]   <= c_d[k];
            sum_q[k] <= sum_d[k];
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_q <= '0;
        end else if (advance) begin
          vld_q[0] <= in_valid;
          for (int k = 1; k < NR; k++) vld_q[k] <= vld_q[k-1];
        end
      end

      assign last_vld = vld_q[NR-1];
    end else begin : g_single
      assign a_q[0]   = '0;
      assign b_q[0]   = '0;
      assign c_q[0]   = 1'b0;
      assign sum_q[0] = '0;
      assign vld_q    = '0;
      assign last_vld = in_valid;
    end
  endgenerate

  // ---- final stage: result and flag registers ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      s_q         <= '0;
      co_q        <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else if (advance) begin
      out_valid_q <= last_vld;
      s_q         <= s_d;
      co_q        <= co_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign co        = co_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Self-checking bench for cla_addsub_pipe (WIDTH=32, STAGES=4): directed cases plus a random stream
// compared against a plain-arithmetic reference model through an expected-result queue.
module tb_cla_addsub_pipe;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;

  logic             clk;
  logic             rst;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] a, b;
  logic             ci, sub;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] s;
  logic             co, ovf, zero;

  cla_addsub_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .co        (co),
    .ovf       (ovf),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] s;
    logic        co;
    logic        ovf;
    logic        zero;
    int          t;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          sent_n = 0;
  int          recv_n = 0;
  bit          lat_on = 1'b0;
  logic [31:0] held;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] es, input logic eco, input logic eovf,
                              input logic ez);
    exp_t e;
    e.s = es; e.co = eco; e.ovf = eovf; e.zero = ez; e.t = 0;
    return e;
  endfunction

  // Reference: whole-word arithmetic, overflow from operand/result signs.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic c, input logic sb);
    exp_t        e;
    logic [31:0] yb;
    logic [32:0] t;
    yb    = sb ? ~y : y;
    t     = {1'b0, x} + {1'b0, yb} + {32'd0, (sb | c)};
    e.s   = t[31:0];
    e.co  = t[32];
    e.ovf = (x[31] == yb[31]) && (t[31] != x[31]);
`ifdef CLA_ADDSUB_SAT_EN
    if (e.ovf) e.s = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    e.zero = (e.s == 32'd0);
    e.t    = 0;
    return e;
  endfunction

  task automatic step(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                      input logic ici, input logic isub, input logic ordy, input exp_t e);
    exp_t g;
    in_valid = iv; a = ia; b = ib; ci = ici; sub = isub; out_ready = ordy;
    #1;
    if (out_valid && out_ready) begin
      total++;
      assert (q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_result: observed s=%h expected no result", s);
      end
      if (q.size() != 0) begin
        g = q.pop_front();
        recv_n++;
        chk("s", s, g.s);
        chk("co", 32'(co), 32'(g.co));
        chk("ovf", 32'(ovf), 32'(g.ovf));
        chk("zero", 32'(zero), 32'(g.zero));
        if (lat_on) chk("latency", 32'(cyc - g.t), 32'(STAGES));
      end
    end
    if (in_valid && in_ready) begin
      e.t = cyc;
      q.push_back(e);
      sent_n++;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, mk(32'd0, 0, 0, 0));
  endtask

  task automatic send(input logic iv, input logic ordy);
    logic [31:0] x, y;
    logic        c, sb;
    x  = $urandom;
    y  = $urandom;
    c  = 1'($urandom_range(0, 1));
    sb = 1'($urandom_range(0, 1));
    step(iv, x, y, c, sb, ordy, model(x, y, c, sb));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_s", s, 32'd0);
    chk("rst_co", 32'(co), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    rst = 1'b0;

    // Directed cases, back to back with the latency checked.
    lat_on = 1'b1;
    step(1, 32'h0000_FFFF, 32'h0000_0001, 0, 0, 1, mk(32'h0001_0000, 0, 0, 0));
    step(1, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0, 1, mk(32'h0000_0000, 1, 0, 1));
`ifdef CLA_ADDSUB_SAT_EN
    step(1, 32'h8000_0000, 32'h0000_0001, 0, 1, 1, mk(32'h8000_0000, 1, 1, 0));
`else
    step(1, 32'h8000_0000, 32'h0000_0001, 0, 1, 1, mk(32'h7FFF_FFFF, 1, 1, 0));
`endif
    step(1, 32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 1, mk(32'h0000_0000, 1, 0, 1));
    step(1, 32'h0000_0005, 32'h0000_0005, 1, 1, 1, mk(32'h0000_0000, 1, 0, 1));
    step(1, 32'h0000_0003, 32'h0000_0005, 0, 1, 1, mk(32'hFFFF_FFFE, 0, 0, 0));
`ifdef CLA_ADDSUB_SAT_EN
    step(1, 32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 1, mk(32'h7FFF_FFFF, 0, 1, 0));
`else
    step(1, 32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 1, mk(32'h8000_0000, 0, 1, 0));
`endif
    idle(STAGES + 2);
    chk("directed_drain", 32'(q.size()), 32'd0);

    // Back-to-back random stream; constant latency implies consecutive outputs.
    for (int i = 0; i < 16; i++) send(1'b1, 1'b1);
    idle(STAGES + 2);
    chk("stream_drain", 32'(q.size()), 32'd0);

    // Backpressure with a full pipe.
    lat_on = 1'b0;
    repeat (5) send(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; out_ready = 1'b0;
      #1;
      if (i == 0) held = s;
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_s_stable", s, held);
      send(1'b1, 1'b0);
    end
    repeat (8) send(1'b1, 1'b1);
    for (int i = 0; i < 40; i++) send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    idle(STAGES + 8);
    chk("bp_drain", 32'(q.size()), 32'd0);
    chk("bp_count", 32'(recv_n), 32'(sent_n));

    // Reset with operations in flight.
    lat_on = 1'b1;
    repeat (5) send(1'b1, 1'b1);
    chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_s", s, 32'd0);
    q.delete();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = 1'b0;
    idle(STAGES + 1);
    step(1, 32'h1234_5678, 32'h1111_1111, 0, 0, 1, mk(32'h2345_6789, 0, 0, 0));
    idle(STAGES + 2);
    chk("post_rst_drain", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
